// File: rtl/dphy_pkg.sv
// Shared D-PHY lane definitions: sequencer states, LP line codes and default widths/bytes.
package dphy_pkg;

    localparam int TW_DEFAULT = 5;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;

    typedef enum logic [2:0] {
        STOP,
        RQST,
        PREP,
        ZERO,
        SYNC,
        DATA,
        TRAIL,
        EXIT
    } lane_state_t;

    // LP codes are {lp_dp, lp_dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/dphy_phase_timer.sv
// Phase timer shared by all timed lane states: counts from zero after clear, done at len-1.
module dphy_phase_timer #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [TW-1:0] len,
    output logic          done
);

    logic [TW-1:0] count_reg;

    // len is never zero here; the sequencer normalises it when latching
    assign done = (count_reg == (len - TW'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (!done) begin
            count_reg <= count_reg + TW'(1);
        end
    end

endmodule

// File: rtl/dphy_hs_lane_sequencer.sv
// Per-lane D-PHY HS transmit sequencer: LP entry, HS leader, payload streaming, trail and exit.
module dphy_hs_lane_sequencer
    import dphy_pkg::*;
#(
    parameter int         TW        = TW_DEFAULT,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tx_request_hs,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic [TW-1:0] t_lpx,
    input  logic [TW-1:0] t_prepare,
    input  logic [TW-1:0] t_zero,
    input  logic [TW-1:0] t_trail,
    input  logic [TW-1:0] t_exit,
    output logic          lp_dp,
    output logic          lp_dn,
    output logic          hs_en,
    output logic [7:0]    hs_data,
    output logic          stop_state,
    output logic          underrun
);

    lane_state_t   state_reg;
    logic [TW-1:0] lpx_reg, prep_reg, zero_reg, trail_reg, exit_reg;
    logic          window_reg;
    logic          last_bit_reg;
    logic [TW-1:0] phase_len;
    logic          phase_done;
    logic          phase_clear;

    function automatic logic [TW-1:0] norm_len(input logic [TW-1:0] n);
        return (n == '0) ? TW'(1) : n;
    endfunction

    // The byte window opens in SYNC so the first payload byte follows the leader with no gap.
    assign tx_ready = tx_request_hs & window_reg;

    always_comb begin
        phase_len = TW'(1);
        case (state_reg)
            RQST:    phase_len = lpx_reg;
            PREP:    phase_len = prep_reg;
            ZERO:    phase_len = zero_reg;
            TRAIL:   phase_len = trail_reg;
            EXIT:    phase_len = exit_reg;
            default: phase_len = TW'(1);
        endcase
    end

    // High exactly when the FSM changes state on the coming edge.
    always_comb begin
        phase_clear = 1'b0;
        case (state_reg)
            STOP:                         phase_clear = tx_request_hs;
            RQST, PREP, ZERO, TRAIL, EXIT: phase_clear = phase_done;
            SYNC:                         phase_clear = 1'b1;
            DATA:                         phase_clear = !tx_request_hs;
            default:                      phase_clear = 1'b1;
        endcase
    end

    dphy_phase_timer #(
        .TW(TW)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .clear (phase_clear),
        .len   (phase_len),
        .done  (phase_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= STOP;
            {lp_dp, lp_dn}  <= LP11;
            hs_en           <= 1'b0;
            hs_data         <= 8'h00;
            stop_state      <= 1'b1;
            underrun        <= 1'b0;
            window_reg      <= 1'b0;
            last_bit_reg    <= SYNC_BYTE[7];
            lpx_reg         <= TW'(1);
            prep_reg        <= TW'(1);
            zero_reg        <= TW'(1);
            trail_reg       <= TW'(1);
            exit_reg        <= TW'(1);
        end else begin
            underrun <= 1'b0;
            case (state_reg)
                STOP: if (tx_request_hs) begin
                    state_reg      <= RQST;
                    {lp_dp, lp_dn} <= LP01;
                    stop_state     <= 1'b0;
                    lpx_reg        <= norm_len(t_lpx);
                    prep_reg       <= norm_len(t_prepare);
                    zero_reg       <= norm_len(t_zero);
                    trail_reg      <= norm_len(t_trail);
                    exit_reg       <= norm_len(t_exit);
                end
                RQST: if (phase_done) begin
                    state_reg      <= PREP;
                    {lp_dp, lp_dn} <= LP00;
                end
                PREP: if (phase_done) begin
                    state_reg <= ZERO;
                    hs_en     <= 1'b1;
                    hs_data   <= 8'h00;
                end
                ZERO: if (phase_done) begin
                    state_reg    <= SYNC;
                    hs_data      <= SYNC_BYTE;
                    last_bit_reg <= SYNC_BYTE[7];
                    window_reg   <= 1'b1;
                end
                SYNC, DATA: begin
                    if (tx_request_hs) begin
                        state_reg <= DATA;
                        if (tx_valid) begin
                            hs_data      <= tx_data;
                            last_bit_reg <= tx_data[7];
                        end else begin
                            underrun <= 1'b1;
                        end
                    end else begin
                        state_reg  <= TRAIL;
                        window_reg <= 1'b0;
                        hs_data    <= {8{~last_bit_reg}};
                    end
                end
                TRAIL: if (phase_done) begin
                    state_reg      <= EXIT;
                    hs_en          <= 1'b0;
                    hs_data        <= 8'h00;
                    {lp_dp, lp_dn} <= LP11;
                end
                EXIT: if (phase_done) begin
                    state_reg  <= STOP;
                    stop_state <= 1'b1;
                end
                default: state_reg <= STOP;
            endcase
        end
    end

endmodule

// File: tb/tb_dphy_hs_lane_sequencer.sv
// Directed bench for the HS lane sequencer: cycle-by-cycle lane vectors against hand-derived values.
module tb_dphy_hs_lane_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_request_hs;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [4:0] t_lpx, t_prepare, t_zero, t_trail, t_exit;
    logic       lp_dp, lp_dn, hs_en;
    logic [7:0] hs_data;
    logic       stop_state, underrun;

    int n_cmp = 0;
    int n_bad = 0;

    // vector layout: {lp_dp, lp_dn, hs_en, stop_state, tx_ready, underrun, hs_data}
    localparam logic [13:0] STOPV = {2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    always #5 clk = ~clk;

    dphy_hs_lane_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .tx_request_hs (tx_request_hs),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .t_lpx         (t_lpx),
        .t_prepare     (t_prepare),
        .t_zero        (t_zero),
        .t_trail       (t_trail),
        .t_exit        (t_exit),
        .lp_dp         (lp_dp),
        .lp_dn         (lp_dn),
        .hs_en         (hs_en),
        .hs_data       (hs_data),
        .stop_state    (stop_state),
        .underrun      (underrun)
    );

    function automatic logic [13:0] v(input logic [1:0] lp, input logic hs, input logic st,
                                      input logic rd, input logic un, input logic [7:0] d);
        return {lp, hs, st, rd, un, d};
    endfunction

    task automatic cmp(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        obs = {lp_dp, lp_dn, hs_en, stop_state, tx_ready, underrun, hs_data};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed lp=%b hs_en=%b stop=%b rdy=%b und=%b data=%h, expected lp=%b hs_en=%b stop=%b rdy=%b und=%b data=%h",
                   tag, obs[13:12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
                   exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
        $display("[%0t] %s lp=%b hs_en=%b stop=%b rdy=%b und=%b data=%h",
                 $time, tag, obs[13:12], obs[11], obs[10], obs[9], obs[8], obs[7:0]);
    endtask

    // Checks n consecutive cycles mid-cycle, leaving time just after the next edge.
    task automatic cyc(input string tag, input int n, input logic [13:0] exp);
        for (int i = 0; i < n; i++) begin
            #2;
            cmp(tag, exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_t(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic [4:0] d, input logic [4:0] e);
        t_lpx = a; t_prepare = b; t_zero = c; t_trail = d; t_exit = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; tx_request_hs = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        set_t(5'd3, 5'd2, 5'd4, 5'd3, 5'd2);
        #1 reset = 1'b1;
        #2 cmp("reset_async", STOPV);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc("idle", 2, STOPV);

        // Nominal sequence with one payload byte
        tx_request_hs = 1'b1;
        cyc("t1_stop", 1, STOPV);
        cyc("t1_lpx", 3, v(2'b01, 0, 0, 0, 0, 8'h00));
        cyc("t1_prep", 2, v(2'b00, 0, 0, 0, 0, 8'h00));
        cyc("t1_zero", 4, v(2'b00, 1, 0, 0, 0, 8'h00));
        tx_valid = 1'b1; tx_data = 8'h5A;
        cyc("t1_sync", 1, v(2'b00, 1, 0, 1, 0, 8'hB8));
        tx_request_hs = 1'b0; tx_valid = 1'b0;
        cyc("t1_data", 1, v(2'b00, 1, 0, 0, 0, 8'h5A));
        cyc("t1_trail", 3, v(2'b00, 1, 0, 0, 0, 8'hFF));
        cyc("t1_exit", 2, v(2'b11, 0, 0, 0, 0, 8'h00));
        cyc("t1_end", 1, STOPV);

        // All timing fields zero: one cycle per timed state, no payload
        set_t(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        tx_request_hs = 1'b1;
        cyc("t2_stop", 1, STOPV);
        tx_request_hs = 1'b0;
        cyc("t2_lpx", 1, v(2'b01, 0, 0, 0, 0, 8'h00));
        cyc("t2_prep", 1, v(2'b00, 0, 0, 0, 0, 8'h00));
        cyc("t2_zero", 1, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t2_sync", 1, v(2'b00, 1, 0, 0, 0, 8'hB8));
        cyc("t2_trail", 1, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t2_exit", 1, v(2'b11, 0, 0, 0, 0, 8'h00));
        cyc("t2_end", 1, STOPV);

        // Request dropped during PREP
        set_t(5'd3, 5'd2, 5'd4, 5'd3, 5'd2);
        tx_request_hs = 1'b1;
        cyc("t3_stop", 1, STOPV);
        cyc("t3_lpx", 3, v(2'b01, 0, 0, 0, 0, 8'h00));
        tx_request_hs = 1'b0;
        cyc("t3_prep", 2, v(2'b00, 0, 0, 0, 0, 8'h00));
        cyc("t3_zero", 4, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t3_sync", 1, v(2'b00, 1, 0, 0, 0, 8'hB8));
        cyc("t3_trail", 3, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t3_exit", 2, v(2'b11, 0, 0, 0, 0, 8'h00));
        cyc("t3_end", 1, STOPV);

        // Two-cycle underrun after byte 81
        set_t(5'd1, 5'd1, 5'd1, 5'd1, 5'd1);
        tx_request_hs = 1'b1;
        cyc("t4_stop", 1, STOPV);
        cyc("t4_lpx", 1, v(2'b01, 0, 0, 0, 0, 8'h00));
        cyc("t4_prep", 1, v(2'b00, 0, 0, 0, 0, 8'h00));
        cyc("t4_zero", 1, v(2'b00, 1, 0, 0, 0, 8'h00));
        tx_valid = 1'b1; tx_data = 8'h11;
        cyc("t4_sync", 1, v(2'b00, 1, 0, 1, 0, 8'hB8));
        tx_data = 8'h81;
        cyc("t4_b11", 1, v(2'b00, 1, 0, 1, 0, 8'h11));
        tx_valid = 1'b0;
        cyc("t4_b81", 1, v(2'b00, 1, 0, 1, 0, 8'h81));
        cyc("t4_und1", 1, v(2'b00, 1, 0, 1, 1, 8'h81));
        tx_valid = 1'b1; tx_data = 8'h22;
        cyc("t4_und2", 1, v(2'b00, 1, 0, 1, 1, 8'h81));
        tx_request_hs = 1'b0; tx_valid = 1'b0;
        cyc("t4_b22", 1, v(2'b00, 1, 0, 0, 0, 8'h22));
        cyc("t4_trail", 1, v(2'b00, 1, 0, 0, 0, 8'hFF));
        cyc("t4_exit", 1, v(2'b11, 0, 0, 0, 0, 8'h00));
        cyc("t4_end", 1, STOPV);

        // Asynchronous reset in ZERO cycle 2, then restart
        set_t(5'd3, 5'd2, 5'd4, 5'd3, 5'd2);
        tx_request_hs = 1'b1;
        cyc("t5_stop", 1, STOPV);
        cyc("t5_lpx", 3, v(2'b01, 0, 0, 0, 0, 8'h00));
        cyc("t5_prep", 2, v(2'b00, 0, 0, 0, 0, 8'h00));
        cyc("t5_zero1", 1, v(2'b00, 1, 0, 0, 0, 8'h00));
        #2 cmp("t5_zero2", v(2'b00, 1, 0, 0, 0, 8'h00));
        #2 reset = 1'b1;
        #1 cmp("t5_rst_async", STOPV);
        #2 reset = 1'b0; tx_request_hs = 1'b0;
        @(posedge clk); #1;
        cyc("t5_idle", 2, STOPV);
        tx_request_hs = 1'b1;
        cyc("t5_stop", 1, STOPV);
        tx_request_hs = 1'b0;
        cyc("t5_lpx", 3, v(2'b01, 0, 0, 0, 0, 8'h00));
        cyc("t5_prep", 2, v(2'b00, 0, 0, 0, 0, 8'h00));
        cyc("t5_zero", 4, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t5_sync", 1, v(2'b00, 1, 0, 0, 0, 8'hB8));
        cyc("t5_trail", 3, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t5_exit", 2, v(2'b11, 0, 0, 0, 0, 8'h00));
        cyc("t5_end", 1, STOPV);

        // t_zero changed during RQST: only the following sequence sees it
        tx_request_hs = 1'b1;
        cyc("t6_stop", 1, STOPV);
        t_zero = 5'd9;
        cyc("t6_lpx", 3, v(2'b01, 0, 0, 0, 0, 8'h00));
        tx_request_hs = 1'b0;
        cyc("t6_prep", 2, v(2'b00, 0, 0, 0, 0, 8'h00));
        cyc("t6_zero4", 4, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t6_sync", 1, v(2'b00, 1, 0, 0, 0, 8'hB8));
        cyc("t6_trail", 3, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t6_exit", 2, v(2'b11, 0, 0, 0, 0, 8'h00));
        cyc("t6_end", 1, STOPV);
        tx_request_hs = 1'b1;
        cyc("t6b_stop", 1, STOPV);
        tx_request_hs = 1'b0;
        cyc("t6b_lpx", 3, v(2'b01, 0, 0, 0, 0, 8'h00));
        cyc("t6b_prep", 2, v(2'b00, 0, 0, 0, 0, 8'h00));
        cyc("t6b_zero9", 9, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t6b_sync", 1, v(2'b00, 1, 0, 0, 0, 8'hB8));
        cyc("t6b_trail", 3, v(2'b00, 1, 0, 0, 0, 8'h00));
        cyc("t6b_exit", 2, v(2'b11, 0, 0, 0, 0, 8'h00));
        cyc("t6b_end", 1, STOPV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
